// File: rtl/batch_fifo_if.sv
// Handshake bundle for batch_fifo.
//   slave  : FIFO view (accepts entries from a producer, offers batches to a consumer)
//   master : environment view (drives producer/consumer side, observes FIFO status)
// Signals:
//   flush_i          synchronous clear of stored contents
//   valid_i/ready_o  per-entry push handshake, data_i carries the entry
//   batch_i          requested batch size (clamped to 1..MAX_BATCH inside the FIFO)
//   valid_o/ready_i  per-batch pop handshake, data_o carries MAX_BATCH lanes
//   batch_o          size of the batch currently offered
//   count_o          number of stored entries
interface batch_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BATCH = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BATCH + 1);

  logic                       flush_i;
  logic                       valid_i;
  logic                       ready_o;
  logic [WIDTH-1:0]           data_i;
  logic [BW-1:0]              batch_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [MAX_BATCH*WIDTH-1:0] data_o;
  logic [BW-1:0]              batch_o;
  logic [CW-1:0]              count_o;

  modport slave (
    input  flush_i, valid_i, data_i, batch_i, ready_i,
    output ready_o, valid_o, data_o, batch_o, count_o
  );

  modport master (
    output flush_i, valid_i, data_i, batch_i, ready_i,
    input  ready_o, valid_o, data_o, batch_o, count_o
  );
endinterface

// File: rtl/batch_fifo.sv
// Single-clock FIFO that accepts one entry per cycle and releases entries in
// batches of a programmable size, one whole batch per consumer handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  batch_fifo_if.slave (push side, pop side, flush, batch size, count)
module batch_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BATCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  batch_fifo_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BATCH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [BW-1:0]    batch_q;

  logic             ready, valid, push, pop;
  logic [BW-1:0]    batch_eff;
  logic [PW-1:0]    wr_next, rd_next;
  logic [PW:0]      rd_sum;
  logic [CW-1:0]    count_next;

  always_comb begin
    if (bus.batch_i == '0)
      batch_eff = BW'(1);
    else if (bus.batch_i > BW'(MAX_BATCH))
      batch_eff = BW'(MAX_BATCH);
    else
      batch_eff = bus.batch_i;
  end

  assign ready = (count_q < CW'(DEPTH));
  assign valid = (count_q >= CW'(batch_q));
  assign push  = bus.valid_i && ready;
  assign pop   = valid && bus.ready_i;

  // Pointer arithmetic wraps explicitly so DEPTH need not be a power of two;
  // rd_ptr + batch_q < 2*DEPTH, so one conditional subtract suffices.
  assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_sum  = {1'b0, rd_ptr} + (PW+1)'(batch_q);
  assign rd_next = (rd_sum >= (PW+1)'(DEPTH)) ? PW'(rd_sum - (PW+1)'(DEPTH))
                                              : PW'(rd_sum);

  assign count_next = count_q + CW'(push) - (pop ? CW'(batch_q) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      batch_q <= BW'(1);
    end else if (bus.flush_i) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      batch_q <= batch_eff;
    end else begin
      if (push) wr_ptr <= wr_next;
      if (pop)  rd_ptr <= rd_next;
      count_q <= count_next;
      // Batch size only changes when no batch is being held for the consumer.
      if (!valid || pop) batch_q <= batch_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush_i && push)
      mem[wr_ptr] <= bus.data_i;
  end

  // Lanes are zeroed while no batch is offered so unwritten storage never
  // leaks onto data_o (gives data_o = 0 straight out of reset).
  logic [PW:0]   lane_sum;
  logic [PW-1:0] lane_addr;
  always_comb begin
    bus.data_o = '0;
    lane_sum   = '0;
    lane_addr  = '0;
    for (int unsigned k = 0; k < MAX_BATCH; k++) begin
      lane_sum  = {1'b0, rd_ptr} + (PW+1)'(k);
      lane_addr = (lane_sum >= (PW+1)'(DEPTH)) ? PW'(lane_sum - (PW+1)'(DEPTH))
                                               : PW'(lane_sum);
      if (valid && (k < 32'(batch_q)))
        bus.data_o[k*WIDTH +: WIDTH] = mem[lane_addr];
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid;
  assign bus.batch_o = batch_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_batch_fifo.sv
module tb_batch_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batch_fifo_if #(.WIDTH(W), .DEPTH(D), .MAX_BATCH(MB)) bus ();
  batch_fifo #(.WIDTH(W), .DEPTH(D), .MAX_BATCH(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic er, input logic ev,
                         input int ec, input int eb, input logic [15:0] ed);
    chk({nm, ".ready_o"}, longint'(bus.ready_o), longint'(er));
    chk({nm, ".valid_o"}, longint'(bus.valid_o), longint'(ev));
    chk({nm, ".count_o"}, longint'(bus.count_o), longint'(ec));
    chk({nm, ".batch_o"}, longint'(bus.batch_o), longint'(eb));
    if (ev) chk({nm, ".data_o"}, longint'(bus.data_o), longint'(ed));
  endtask

  typedef struct {
    logic       rst, flush, valid;
    logic [7:0] data;
    logic [1:0] batch;
    logic       rdy;
    logic       e_ready, e_valid;
    int         e_count, e_batch;
    logic [15:0] e_data;
  } vec_t;

  function automatic vec_t mk(logic f, logic v, logic [7:0] d, logic [1:0] b, logic r,
                              logic er, logic ev, int ec, int eb, logic [15:0] ed);
    vec_t t;
    t.rst = 1'b0; t.flush = f; t.valid = v; t.data = d; t.batch = b; t.rdy = r;
    t.e_ready = er; t.e_valid = ev; t.e_count = ec; t.e_batch = eb; t.e_data = ed;
    return t;
  endfunction

  function automatic int eff(int b);
    if (b == 0) return 1;
    if (b > MB) return MB;
    return b;
  endfunction

  task automatic drive(logic r, logic f, logic v, logic [7:0] d, logic [1:0] b, logic rd);
    rst = r; bus.flush_i = f; bus.valid_i = v; bus.data_i = d;
    bus.batch_i = b; bus.ready_i = rd;
  endtask

  // One cycle: drive away from the edge, sample 1 time unit after it.
  task automatic step(logic r, logic f, logic v, logic [7:0] d, logic [1:0] b, logic rd);
    @(negedge clk);
    drive(r, f, v, d, b, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic fill3();
    step(0, 1, 0, 8'h00, 2, 0);
    step(0, 0, 1, 8'hC1, 2, 0);
    step(0, 0, 1, 8'hC2, 2, 0);
    step(0, 0, 1, 8'hC3, 2, 0);
    chk_out("fill3", 1, 1, 3, 2, 16'hC2C1);
  endtask

  vec_t tbl[$];
  byte unsigned q[$];
  int mbq;

  initial begin
    drive(1, 0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_out("reset", 1, 0, 0, 1, 16'h0000);
    chk("reset.data_o", longint'(bus.data_o), 0);

    //             fl v  data   b  rdy  er ev cnt bo data
    tbl.push_back(mk(0, 1, 8'hA1, 2, 0,  1, 0, 1, 2, 16'h0000));
    tbl.push_back(mk(0, 1, 8'hB2, 2, 0,  1, 1, 2, 2, 16'hB2A1));
    tbl.push_back(mk(0, 0, 8'h00, 2, 1,  1, 0, 0, 2, 16'h0000));
    tbl.push_back(mk(0, 1, 8'h01, 2, 0,  1, 0, 1, 2, 16'h0000));
    tbl.push_back(mk(0, 1, 8'h02, 2, 0,  1, 1, 2, 2, 16'h0201));
    tbl.push_back(mk(0, 1, 8'h03, 2, 0,  1, 1, 3, 2, 16'h0201));
    tbl.push_back(mk(0, 1, 8'h04, 2, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 1, 8'h05, 2, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 0, 8'h00, 3, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 1, 4, 2, 16'h0201));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1,  1, 1, 2, 1, 16'h0003));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1,  1, 1, 1, 1, 16'h0004));
    tbl.push_back(mk(0, 0, 8'h00, 3, 1,  1, 0, 0, 2, 16'h0000));
    tbl.push_back(mk(1, 0, 8'h00, 2, 0,  1, 0, 0, 2, 16'h0000));
    tbl.push_back(mk(0, 1, 8'h11, 2, 0,  1, 0, 1, 2, 16'h0000));
    tbl.push_back(mk(0, 1, 8'h22, 2, 0,  1, 1, 2, 2, 16'h2211));
    tbl.push_back(mk(0, 1, 8'h33, 2, 0,  1, 1, 3, 2, 16'h2211));
    tbl.push_back(mk(0, 1, 8'h44, 2, 1,  1, 1, 2, 2, 16'h4433));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].data, tbl[i].batch, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid,
              tbl[i].e_count, tbl[i].e_batch, tbl[i].e_data);
    end

    // Flush with a concurrent push: the pushed entry must be dropped.
    fill3();
    step(0, 1, 1, 8'hEE, 2, 1);
    chk_out("flush", 1, 0, 0, 2, 16'h0000);
    step(0, 0, 0, 8'h00, 2, 0);
    chk_out("flush.after", 1, 0, 0, 2, 16'h0000);

    // Same with reset: also returns batch size to 1.
    fill3();
    step(1, 0, 1, 8'hEE, 2, 1);
    chk_out("rst_mid", 1, 0, 0, 1, 16'h0000);
    chk("rst_mid.data_o", longint'(bus.data_o), 0);

    // Randomised run against a queue model.
    q.delete();
    mbq = 1;
    for (int n = 0; n < 3000; n++) begin
      logic r, f, v, rd, mv, pushm, popm;
      logic [7:0] d;
      logic [1:0] b;
      logic [15:0] ed;
      @(negedge clk);
      mv = (q.size() >= mbq);
      ed = '0;
      if (mv) for (int k = 0; k < mbq; k++) ed[k*8 +: 8] = q[k];
      chk_out($sformatf("rand%0d", n), q.size() < D, mv, q.size(), mbq, ed);

      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      b  = 2'($urandom_range(0, 3));
      drive(r, f, v, d, b, rd);

      if (r) begin
        q.delete(); mbq = 1;
      end else if (f) begin
        q.delete(); mbq = eff(int'(b));
      end else begin
        pushm = v && (q.size() < D);
        popm  = mv && rd;
        if (popm) repeat (mbq) void'(q.pop_front());
        if (pushm) q.push_back(d);
        if (!mv || popm) mbq = eff(int'(b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/batch_fifo.md
Name: batch_fifo

Overview:
Parametrised single-clock FIFO. It accepts one WIDTH-bit entry per cycle on a valid/ready slave port and releases entries in batches of a programmable size on a valid/ready master port. A batch is offered only once the number of stored entries reaches the programmed batch size, and the whole batch is consumed in one handshake. It sits between a per-item producer and a consumer that processes grouped items, for example packers or multi-lane engines.

Parameters:
WIDTH, 8, bits per entry
DEPTH, 4, storage entries; must be >= 2 and >= MAX_BATCH; any integer, not only powers of two
MAX_BATCH, 2, largest batch released per pop; must be >= 1
CW, $clog2(DEPTH+1), derived width of the count fields
BW, $clog2(MAX_BATCH+1), derived width of the batch fields

Ports:
clk  in  1  clock; all logic is on its rising edge
rst  in  1  reset, synchronous, active-high
flush_i  in  1  synchronous clear of stored contents
valid_i  in  1  producer entry valid
ready_o  out  1  FIFO can accept an entry
data_i  in  WIDTH  producer entry
batch_i  in  BW  requested batch size
valid_o  out  1  full batch available
ready_i  in  1  consumer accepts the batch
data_o  out  MAX_BATCH*WIDTH  batch data; lane k is bits [k*WIDTH +: WIDTH]
batch_o  out  BW  size of the batch currently offered
count_o  out  CW  number of stored entries

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count_q=0, wr_ptr=0, rd_ptr=0, batch_q=1. Outputs after reset: ready_o=1, valid_o=0, batch_o=1, count_o=0, data_o=0. Storage contents are not reset.
- Reset asserted mid-operation discards all entries and any pending batch on the next edge. Pushes and pops in that cycle are ignored.
- push = valid_i && ready_o.
- ready_o = (count_q < DEPTH). It depends on registered state only and never on ready_i, so there is no same-cycle pass-through when full.
- pop = valid_o && ready_i.
- valid_o = (count_q >= batch_q).
- batch_o = batch_q.
- count_o = count_q.
- Batch size clamp: eff(batch_i) = 1 if batch_i == 0; MAX_BATCH if batch_i > MAX_BATCH; otherwise batch_i.
- batch_q load rule: batch_q <= eff(batch_i) on any edge where !valid_o || pop.
  - While valid_o=1 and ready_i=0, batch_q, batch_o and data_o hold stable.
  - A new batch size takes effect the cycle after it is loaded.
- data_o lane k (0 <= k < MAX_BATCH) = mem[(rd_ptr+k) mod DEPTH] when k < batch_q. Otherwise the lane is 0.
- data_o is combinational from registered state and is meaningful only while valid_o=1.
- Write: on push, mem[wr_ptr] <= data_i and wr_ptr <= (wr_ptr+1) mod DEPTH, with explicit wrap at DEPTH-1 -> 0.
- Read: on pop, rd_ptr <= (rd_ptr+batch_q) mod DEPTH, computed with explicit wrap.
- Count: count_q <= count_q + push - (pop ? batch_q : 0). A simultaneous push and pop is legal and both take effect; the count never goes below zero.
- Latency: an entry pushed at edge N counts toward valid_o from cycle N+1. There is no fall-through.
- Full: when count_q == DEPTH, ready_o=0. A pop in that cycle frees entries that become available from the next cycle.
- Empty or partial: when count_q < batch_q, valid_o=0 even if entries are present.
- flush_i: on the next edge count_q=0, wr_ptr=0, rd_ptr=0. batch_q loads per the normal rule because valid_o is effectively low. Push and pop in the flush cycle are ignored. rst has priority over flush_i.
- No internal state machine beyond the pointers, count and batch register. The count/batch comparison is the only gating condition.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> ready_o=1, valid_o=0, count_o=0, batch_o=1.
- Batch of 2 (WIDTH=8): batch_i=2; push 0xA1 then 0xB2 -> valid_o rises the cycle after the second push with data_o=0xB2A1. Pop -> count_o=0 and valid_o=0 on the next cycle.
- Full with back-pressure: ready_i=0; push 0x01..0x04 -> count_o=4 and ready_o=0. A fifth valid_i is ignored. data_o=0x0201 holds for 5 stalled cycles.
- Wrap and simultaneous events: from count 3, with wr_ptr=3 and rd_ptr=0, push and pop a batch of 2 in the same cycle -> count_o=2, wr_ptr=0, rd_ptr=2. The next offered batch is {entry4, entry3}.
- Clamp and stability: batch_i=0 -> batch_o=1, and a single entry produces valid_o. batch_i=3 with MAX_BATCH=2 -> batch_o=2. Changing batch_i while stalled leaves batch_o unchanged until the pop.
- Flush and mid-operation reset: with 3 entries stored and valid_o=1, assert flush_i together with valid_i -> count_o=0 and valid_o=0, and the pushed entry is dropped. Repeat with rst -> identical result, with batch_o=1.
